program_loader: RTL

- Writer side of the instruction memory programming port.
- Accepts a framed little-endian byte stream from the host link (UART receiver) and assembles it into HALF_WORD instructions.
- Issues one-cycle write strobes with address and data to instruction memory, and holds the core in load mode until the frame completes.
- Verifies an XOR checksum and reports done/error to the top level.

---
 rtl/program_loader_pkg.sv | 22 ++
 rtl/program_loader_if.sv | 31 +++
 rtl/program_loader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package program_loader_pkg;

    localparam int HALF_WORD = 16;
    localparam int WORD      = 32;

    typedef logic [HALF_WORD-1:0] half_word_t;
    typedef logic [WORD-1:0]      word_t;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        WRITE,
        CHECK
    } loader_state_t;

    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
interface program_loader_if;
    import program_loader_pkg::*;

    logic       byte_valid_i;
    logic [7:0] byte_i;
    logic       byte_ready_o;
    logic       program_mem_write_en_o;
    word_t      instruction_addr_o;
    half_word_t instruction_o;

    // slave: the loader itself; master: the host link / memory side
    modport slave (
        input  byte_valid_i,
        input  byte_i,
        output byte_ready_o,
        output program_mem_write_en_o,
        output instruction_addr_o,
        output instruction_o
    );

    modport master (
        output byte_valid_i,
        output byte_i,
        input  byte_ready_o,
        input  program_mem_write_en_o,
        input  instruction_addr_o,
        input  instruction_o
    );

endinterface

// File: rtl/program_loader.sv
// Parses a framed little-endian byte stream into 16-bit instruction writes,
// verifies an XOR checksum and reports done/error.
module program_loader
    import program_loader_pkg::*;
#(
    parameter word_t       BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE = LOADER_SYNC_BYTE,
    parameter int unsigned ADDR_STEP = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    program_loader_if.slave   bus,
    output logic              loading_o,
    output logic              load_done_o,
    output logic              load_error_o
);

    loader_state_t r_state;
    loader_state_t w_state_next;
    logic [15:0]   r_len;
    logic [15:0]   r_count;
    logic [7:0]    r_chk;
    logic [7:0]    r_lo;
    half_word_t    r_instr;
    word_t         r_addr;
    logic          r_loading;
    logic          r_done;
    logic          r_err;

    logic          w_ready;
    logic          w_write;
    logic          w_accept;
    logic [7:0]    w_byte;

    assign w_byte   = bus.byte_i;
    assign w_accept = bus.byte_valid_i && w_ready;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_byte == SYNC_BYTE) w_state_next = LEN_LO;
            LEN_LO:  if (w_accept) w_state_next = LEN_HI;
            LEN_HI:  if (w_accept) w_state_next = ({w_byte, r_len[7:0]} == 16'd0) ? CHECK : DATA_LO;
            DATA_LO: if (w_accept) w_state_next = DATA_HI;
            DATA_HI: if (w_accept) w_state_next = WRITE;
            // count is compared before its increment so LEN=FFFF never wraps it
            WRITE:   w_state_next = ((r_count + 16'd1) == r_len) ? CHECK : DATA_LO;
            CHECK:   if (w_accept) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Strobe is masked during reset so an interrupted WRITE never reaches memory
    always_comb begin
        w_ready = (r_state != WRITE);
        w_write = (r_state == WRITE) && !reset_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_len     <= '0;
            r_count   <= '0;
            r_chk     <= '0;
            r_lo      <= '0;
            r_instr   <= '0;
            r_addr    <= BASE_ADDR;
            r_loading <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_accept && w_byte == SYNC_BYTE) begin
                    r_chk     <= '0;
                    r_err     <= 1'b0;
                    r_loading <= 1'b1;
                    r_addr    <= BASE_ADDR;
                    r_count   <= '0;
                end
                LEN_LO: if (w_accept) begin
                    r_len[7:0] <= w_byte;
                    r_chk      <= r_chk ^ w_byte;
                end
                LEN_HI: if (w_accept) begin
                    r_len[15:8] <= w_byte;
                    r_chk       <= r_chk ^ w_byte;
                end
                DATA_LO: if (w_accept) begin
                    r_lo  <= w_byte;
                    r_chk <= r_chk ^ w_byte;
                end
                DATA_HI: if (w_accept) begin
                    r_instr <= {w_byte, r_lo};
                    r_chk   <= r_chk ^ w_byte;
                end
                WRITE: begin
                    r_addr  <= r_addr + word_t'(ADDR_STEP);
                    r_count <= r_count + 16'd1;
                end
                CHECK: if (w_accept) begin
                    r_loading <= 1'b0;
                    if (w_byte == r_chk) r_done <= 1'b1;
                    else                 r_err  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready_o           = w_ready;
    assign bus.program_mem_write_en_o = w_write;
    assign bus.instruction_addr_o     = r_addr;
    assign bus.instruction_o          = r_instr;
    assign loading_o                  = r_loading;
    assign load_done_o                = r_done;
    assign load_error_o               = r_err;

endmodule
